// File: rtl/core_c1_mem_arb_if.sv
// Bundle of the fetch, load/store and memory-port signals around core_c1_mem_arb.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface core_c1_mem_arb_if;
    // Instruction fetch
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_gnt;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;

    // Load/store unit
    logic        lsu_req;
    logic        lsu_we;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [1:0]  lsu_size;
    logic        lsu_gnt;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;

    // Memory port
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic [31:0] mem_rdata;

    // Execution stall
    logic        exu_pause;

    modport master (
        output ifu_req, ifu_addr,
        input  ifu_gnt, ifu_rvalid, ifu_rdata,
        output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_size,
        input  lsu_gnt, lsu_rvalid, lsu_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_size,
        output mem_rdata,
        input  exu_pause
    );

    modport slave (
        input  ifu_req, ifu_addr,
        output ifu_gnt, ifu_rvalid, ifu_rdata,
        input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_size,
        output lsu_gnt, lsu_rvalid, lsu_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_size,
        input  mem_rdata,
        output exu_pause
    );
endinterface

// File: rtl/core_c1_mem_arb.sv
// Fetch/LSU arbiter for the single-port synchronous memory, LSU has fixed priority.
// Define CORE_C1_ARB_STREAK_GUARD_EN to let IFU win after MAX_LSU_STREAK contested LSU grants.
module core_c1_mem_arb #(
    parameter int unsigned MAX_LSU_STREAK = 4
) (
    input logic              clk,
    input logic              rst,
    core_c1_mem_arb_if.slave bus
);

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnIfu  = 2'd1,
        OwnLsu  = 2'd2
    } owner_e;

    owner_e rsp_owner_q, rsp_owner_d;

    logic ifu_elig;
    logic lsu_elig;
    logic force_ifu;
    logic ifu_gnt;
    logic lsu_gnt;
    logic ifu_rvalid;
    logic lsu_rvalid;

    // A requester holds its request into its own response cycle; it must not be re-granted then.
    assign ifu_elig = bus.ifu_req && (rsp_owner_q != OwnIfu);
    assign lsu_elig = bus.lsu_req && (rsp_owner_q != OwnLsu);

`ifdef CORE_C1_ARB_STREAK_GUARD_EN
    localparam logic [3:0] MaxStreak = 4'(MAX_LSU_STREAK);

    logic [3:0] lsu_streak_q, lsu_streak_d;

    assign force_ifu = ifu_elig && lsu_elig && (lsu_streak_q == MaxStreak);

    always_comb begin
        lsu_streak_d = lsu_streak_q;
        if (!ifu_elig || ifu_gnt) begin
            lsu_streak_d = 4'd0;
        end else if (lsu_gnt && (lsu_streak_q != 4'hF)) begin
            lsu_streak_d = lsu_streak_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_streak_q <= 4'd0;
        end else begin
            lsu_streak_q <= lsu_streak_d;
        end
    end
`else
    logic [3:0] unused_max_lsu_streak;

    assign unused_max_lsu_streak = 4'(MAX_LSU_STREAK);
    assign force_ifu             = 1'b0;
`endif

    // Grants are suppressed while reset is asserted so no access reaches memory.
    always_comb begin
        ifu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        if (!rst) begin
            if (lsu_elig && !force_ifu) begin
                lsu_gnt = 1'b1;
            end else if (ifu_elig) begin
                ifu_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        rsp_owner_d = OwnNone;
        if (ifu_gnt) begin
            rsp_owner_d = OwnIfu;
        end else if (lsu_gnt && !bus.lsu_we) begin
            rsp_owner_d = OwnLsu;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_owner_q <= OwnNone;
        end else begin
            rsp_owner_q <= rsp_owner_d;
        end
    end

    // A read pending when reset hits is dropped, including in the reset cycle itself.
    assign ifu_rvalid = !rst && (rsp_owner_q == OwnIfu);
    assign lsu_rvalid = !rst && (rsp_owner_q == OwnLsu);

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.mem_size  = 2'd0;
        if (ifu_gnt) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.ifu_addr;
        end else if (lsu_gnt) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.lsu_we;
            bus.mem_addr  = bus.lsu_addr;
            bus.mem_wdata = bus.lsu_wdata;
            bus.mem_size  = bus.lsu_size;
        end
    end

    assign bus.ifu_gnt    = ifu_gnt;
    assign bus.lsu_gnt    = lsu_gnt;
    assign bus.ifu_rvalid = ifu_rvalid;
    assign bus.lsu_rvalid = lsu_rvalid;
    assign bus.ifu_rdata  = bus.mem_rdata;
    assign bus.lsu_rdata  = bus.mem_rdata;

    // Stores finish at grant, loads when their data returns.
    assign bus.exu_pause = bus.lsu_req && (bus.lsu_we ? !lsu_gnt : !lsu_rvalid);

endmodule
